// File: rtl/register_file_wb.sv
// Architectural integer register file for the RV32I pipeline.
// Write side driven by writeback, two bypassed combinational read ports for decode.
module register_file_wb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [31:0]     wb_count,
    output logic            wb_valid_q,
    output logic [4:0]      wb_rd_q
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_d;
    logic            commit;

    // A write to x0 is architecturally a no-op.
    assign commit = RegWriteW && (RdW != 5'd0);
    assign cnt_d  = cnt_q + 32'd1;
    assign wb_count = cnt_q;

    // Register array: reset wins over a write in the same cycle; x0 is never stored.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREG; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (commit && (RdW == 5'(i))) begin
                regs_q[i] <= ResultW;
            end
        end
    end

    // Commit counter and last-write debug flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
        end else begin
            wb_valid_q <= commit;
            if (commit) begin
                cnt_q   <= cnt_d;
                wb_rd_q <= RdW;
            end
        end
    end

    // Read ports: x0 reads zero, a same-cycle commit to the index bypasses the array.
    always_comb begin
        RD1D = '0;
        RD2D = '0;
        for (int i = 1; i < NREG; i++) begin
            if (Rs1D == 5'(i)) begin
                RD1D = regs_q[i];
            end
            if (Rs2D == 5'(i)) begin
                RD2D = regs_q[i];
            end
        end
        if (commit && (RdW == Rs1D)) begin
            RD1D = ResultW;
        end
        if (commit && (RdW == Rs2D)) begin
            RD2D = ResultW;
        end
    end

endmodule
